dds_spi_master: RTL and testbench

Parametrised, write-only SPI master for the DDS control path. It replaces the fixed 16-bit single-slave serialiser with a small design that has these features:
- a command FIFO;
- NUM_CS chip selects;
- a runtime-selectable SPI mode (CPOL/CPHA);
- a programmable SCK divider;
- optional per-channel suppression of writes identical to the last word sent.

All logic is synchronous to clk; SCK is generated as a registered output, never used as a clock.

---
 rtl/dds_spi_pkg.sv | 35 +++
 rtl/dds_cmd_fifo.sv | 53 +++++
 rtl/dds_spi_master.sv | 242 ++++++++++++++++++++++++
 tb/tb_dds_spi_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_spi_pkg.sv
// dds_spi_pkg
// Shared definitions for the DDS SPI control path: the SPI master FSM state
// encoding, the SPI mode encoding ({CPOL, CPHA}) and the default frame width
// and channel count that the register block also relies on.
package dds_spi_pkg;

  localparam int DDS_DATA_W = 16;
  localparam int DDS_NUM_CS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_e;

  // Mode number matches the usual SPI convention: bit 1 = CPOL, bit 0 = CPHA.
  typedef enum logic [1:0] {
    SPI_MODE0 = 2'b00,
    SPI_MODE1 = 2'b01,
    SPI_MODE2 = 2'b10,
    SPI_MODE3 = 2'b11
  } spi_mode_e;

  function automatic logic mode_cpol(input spi_mode_e m);
    return m[1];
  endfunction

  function automatic logic mode_cpha(input spi_mode_e m);
    return m[0];
  endfunction

endpackage

// File: rtl/dds_cmd_fifo.sv
// dds_cmd_fifo
// Small synchronous FIFO holding {channel, word} commands for the SPI master.
// Ports:
//   clk, rstn       clock, asynchronous active-low reset
//   push_i, din_i   write strobe and data (ignored while full)
//   pop_i, dout_o   read strobe and head-of-queue data (ignored while empty)
//   full_o, empty_o occupancy flags
module dds_cmd_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/dds_spi_master.sv
// dds_spi_master
// Write-only SPI master for the DDS control path. Commands are queued in a
// small FIFO and serialised MSB first to one of NUM_CS slaves, in a SPI mode
// chosen per frame from cpol_i/cpha_i. A command equal to the last word sent
// on the same channel can optionally be suppressed.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   wr_data_i/wr_cs_i/wr_valid_i, wr_ready_o   command push handshake
//   cpol_i, cpha_i   SPI mode, latched when a command is popped
//   sck_o, mosi_o, cs_n_o   SPI pins (all registered)
//   busy_o           frame in progress or commands queued
//   frame_done_o     one-cycle pulse as cs_n rises
//   dup_drop_o       one-cycle pulse when a duplicate command is dropped
//   overflow_o       sticky flag: a write was attempted while full
// Parameters CS_SETUP, CS_HOLD and CS_GAP must be at least 1.
module dds_spi_master
  import dds_spi_pkg::*;
#(
  parameter int DATA_W     = DDS_DATA_W,
  parameter int NUM_CS     = DDS_NUM_CS,
  parameter int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2,
  parameter int CS_SETUP   = 1,
  parameter int CS_HOLD    = 1,
  parameter int CS_GAP     = 2,
  parameter bit SKIP_DUP   = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [CS_W-1:0]   wr_cs_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic              cpol_i,
  input  logic              cpha_i,
  output logic              sck_o,
  output logic              mosi_o,
  output logic [NUM_CS-1:0] cs_n_o,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic              dup_drop_o,
  output logic              overflow_o
);

  localparam int CNT_W = $clog2(2 * DATA_W + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  // Last-word storage is sized to the full index range so any cs value
  // indexes it without width games; out-of-range slots are simply never used.
  localparam int SLOTS = 1 << CS_W;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] SHIFT_END  = CNT_W'(2 * DATA_W);

  logic [DATA_W+CS_W-1:0] fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  spi_state_e             state_q;
  spi_mode_e              mode_q;
  logic [DIV_W-1:0]       div_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [DATA_W-1:0]      sr_q;
  logic [DATA_W-1:0]      word_q;
  logic [CS_W-1:0]        cs_q;
  logic [DATA_W-1:0]      last_word_q [SLOTS];
  logic [SLOTS-1:0]       last_valid_q;
  logic                   sck_q;
  logic                   mosi_q;
  logic [NUM_CS-1:0]      cs_n_q;
  logic                   frame_done_q;
  logic                   dup_drop_q;
  logic                   overflow_q;

  logic [CS_W-1:0]        head_cs;
  logic [DATA_W-1:0]      head_word;
  logic                   head_valid;
  logic                   half_end;
  logic                   gap_end;
  logic                   dup_hit;

  assign push = wr_valid_i & ~fifo_full;

  dds_cmd_fifo #(
    .W     (DATA_W + CS_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ({wr_cs_i, wr_data_i}),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_cs    = fifo_dout[DATA_W +: CS_W];
  assign head_word  = fifo_dout[DATA_W-1:0];
  assign head_valid = int'(head_cs) < NUM_CS;
  assign half_end   = (div_q == DIV_LAST);
  assign gap_end    = (state_q == ST_GAP) && (cnt_q == GAP_LAST);
  // The last GAP cycle may pop directly so back-to-back frames need no extra
  // IDLE cycle; the cs_n high time is still CS_GAP plus the LOAD cycle.
  assign pop        = ((state_q == ST_IDLE) || gap_end) && !fifo_empty;
  assign dup_hit    = SKIP_DUP && last_valid_q[cs_q] && (last_word_q[cs_q] == word_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      mode_q       <= SPI_MODE0;
      div_q        <= '0;
      cnt_q        <= '0;
      sr_q         <= '0;
      word_q       <= '0;
      cs_q         <= '0;
      last_valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) last_word_q[i] <= '0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
      cs_n_q       <= '1;
      frame_done_q <= 1'b0;
      dup_drop_q   <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      dup_drop_q   <= 1'b0;
      if (wr_valid_i && fifo_full) overflow_q <= 1'b1;

      // Commands addressed to a nonexistent channel are popped and forgotten.
      if (pop) begin
        sr_q   <= head_word;
        word_q <= head_word;
        cs_q   <= head_cs;
        mode_q <= spi_mode_e'({cpol_i, cpha_i});
      end

      case (state_q)
        ST_IDLE: begin
          sck_q  <= cpol_i;
          mosi_q <= 1'b0;
          if (pop && head_valid) state_q <= ST_LOAD;
        end

        ST_LOAD: begin
          sck_q <= mode_cpol(mode_q);
          div_q <= '0;
          cnt_q <= '0;
          if (dup_hit) begin
            dup_drop_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            cs_n_q  <= ~(NUM_CS'(1) << cs_q);
            state_q <= ST_SETUP;
            // CPHA=0 slaves sample on the first edge, so the MSB goes out now.
            if (!mode_cpha(mode_q)) begin
              mosi_q <= sr_q[DATA_W-1];
              sr_q   <= sr_q << 1;
            end else begin
              mosi_q <= 1'b0;
            end
          end
        end

        ST_SETUP: begin
          div_q <= half_end ? '0 : div_q + 1'b1;
          if (half_end) begin
            if (cnt_q == SETUP_LAST) begin
              sck_q   <= ~sck_q;
              cnt_q   <= CNT_W'(1);
              state_q <= ST_SHIFT;
              if (mode_cpha(mode_q)) begin
                mosi_q <= sr_q[DATA_W-1];
                sr_q   <= sr_q << 1;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        // cnt_q counts SCK toggles already made; even toggles are leading
        // edges. Data advances on leading edges for CPHA=1, trailing for 0.
        ST_SHIFT: begin
          div_q <= half_end ? '0 : div_q + 1'b1;
          if (half_end) begin
            if (cnt_q == SHIFT_END) begin
              cnt_q   <= '0;
              state_q <= ST_HOLD;
            end else begin
              sck_q <= ~sck_q;
              cnt_q <= cnt_q + 1'b1;
              if (mode_cpha(mode_q) == ~cnt_q[0]) begin
                mosi_q <= sr_q[DATA_W-1];
                sr_q   <= sr_q << 1;
              end
            end
          end
        end

        ST_HOLD: begin
          div_q <= half_end ? '0 : div_q + 1'b1;
          if (half_end) begin
            if (cnt_q == HOLD_LAST) begin
              cs_n_q             <= '1;
              frame_done_q       <= 1'b1;
              last_word_q[cs_q]  <= word_q;
              last_valid_q[cs_q] <= 1'b1;
              cnt_q              <= '0;
              state_q            <= ST_GAP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end

        ST_GAP: begin
          mosi_q <= 1'b0;
          cnt_q  <= cnt_q + 1'b1;
          if (gap_end) state_q <= (pop && head_valid) ? ST_LOAD : ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign wr_ready_o   = ~fifo_full;
  assign busy_o       = (state_q != ST_IDLE) | ~fifo_empty;
  assign sck_o        = sck_q;
  assign mosi_o       = mosi_q;
  assign cs_n_o       = cs_n_q;
  assign frame_done_o = frame_done_q;
  assign dup_drop_o   = dup_drop_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_dds_spi_master.sv
// tb_dds_spi_master
// Self-checking bench for dds_spi_master. A pin-level monitor decodes every
// SPI frame from sck/mosi/cs_n; a reference model turns each accepted write
// into the frame (or drop) it should produce and the two are compared.
`timescale 1ns/1ps
module tb_dds_spi_master;

  localparam int DATA_W = 16;
  localparam int NUM_CS = 2;
  localparam int CS_W   = 2;
  localparam int CS_GAP = 2;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] wrData = '0;
  logic [CS_W-1:0]   wrCs = '0;
  logic              wrValid = 1'b0;
  logic              wrReady;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic              sck;
  logic              mosi;
  logic [NUM_CS-1:0] csN;
  logic              busy;
  logic              frameDone;
  logic              dupDrop;
  logic              overflow;

  always #5 clk = ~clk;

  dds_spi_master #(
    .DATA_W(DATA_W), .NUM_CS(NUM_CS), .CS_W(CS_W), .FIFO_DEPTH(4),
    .CLK_DIV(2), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(CS_GAP), .SKIP_DUP(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn),
    .wr_data_i(wrData), .wr_cs_i(wrCs), .wr_valid_i(wrValid), .wr_ready_o(wrReady),
    .cpol_i(cpol), .cpha_i(cpha),
    .sck_o(sck), .mosi_o(mosi), .cs_n_o(csN),
    .busy_o(busy), .frame_done_o(frameDone), .dup_drop_o(dupDrop), .overflow_o(overflow)
  );

  typedef struct {
    int                cs;
    logic [DATA_W-1:0] word;
    int                bits;
    int                edges;
    bit                idleOk;
  } obs_t;

  typedef struct {
    int                cs;
    logic [DATA_W-1:0] word;
  } exp_t;

  int vectors = 0;
  int miscompares = 0;

  // reference model: what the channel memory should hold and what must go out
  bit                lastValid [NUM_CS];
  logic [DATA_W-1:0] lastWord  [NUM_CS];
  exp_t              expQ[$];
  int                expFrames;
  int                expDups;

  // pin monitor state
  obs_t              obsQ[$];
  obs_t              monFrame;
  bit                inFrame = 1'b0;
  logic              prevSck;
  logic [NUM_CS-1:0] prevCs = '1;
  bit                fCpol, fCpha;
  int                monBits = 0;
  int                gapCnt = 1000;
  int                minGap = 1000;
  int                fdPulses = 0;
  int                fdBad = 0;
  int                dupPulses = 0;
  int                multiLow = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      inFrame = 1'b0;
      gapCnt  = 1000;
      prevCs  = '1;
      prevSck = sck;
      monBits = 0;
    end else begin
      if (frameDone) begin
        fdPulses++;
        if (!(prevCs != '1 && csN == '1)) fdBad++;
      end
      if (dupDrop) dupPulses++;
      if ($countones(~csN) > 1) multiLow++;
      if (!inFrame && csN != '1) begin
        inFrame         = 1'b1;
        monFrame.cs     = (csN == 2'b10) ? 0 : 1;
        monFrame.word   = '0;
        monFrame.edges  = 0;
        monFrame.idleOk = (sck === cpol);
        monBits         = 0;
        fCpol           = cpol;
        fCpha           = cpha;
        if (gapCnt < minGap) minGap = gapCnt;
      end else if (inFrame && csN == '1) begin
        inFrame         = 1'b0;
        monFrame.bits   = monBits;
        monFrame.idleOk = monFrame.idleOk && (sck === fCpol);
        obsQ.push_back(monFrame);
        gapCnt = 1;
      end else if (inFrame) begin
        if (sck !== prevSck) begin
          monFrame.edges++;
          // sample on the leading edge for CPHA=0, trailing edge for CPHA=1
          if ((sck !== fCpol) == (fCpha == 1'b0)) begin
            monFrame.word = {monFrame.word[DATA_W-2:0], mosi};
            monBits++;
          end
        end
      end else begin
        gapCnt++;
      end
      prevCs  = csN;
      prevSck = sck;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelAccept(input logic [DATA_W-1:0] word, input int cs);
    exp_t e;
    if (cs >= NUM_CS) return;
    if (lastValid[cs] && lastWord[cs] == word) begin
      expDups++;
    end else begin
      e.cs   = cs;
      e.word = word;
      expQ.push_back(e);
      expFrames++;
      lastValid[cs] = 1'b1;
      lastWord[cs]  = word;
    end
  endtask

  // Called on a negedge; drives one write for exactly one rising edge.
  task automatic applyStimulus(input logic [DATA_W-1:0] word, input int cs,
                               input bit expReady);
    wrData  = word;
    wrCs    = CS_W'(cs);
    wrValid = 1'b1;
    checkOutput("wr_ready before write", wrReady, expReady);
    if (expReady) modelAccept(word, cs);
    @(negedge clk);
    wrValid = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NUM_CS; i++) lastValid[i] = 1'b0;
    expQ.delete();
    obsQ.delete();
    @(negedge clk);
  endtask

  task automatic startSection();
    fdPulses = 0; fdBad = 0; dupPulses = 0; multiLow = 0;
    minGap = 1000; expFrames = 0; expDups = 0;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || csN !== '1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " drained in budget"}, 32'(n < budget), 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic endSection(input string tag, input int budget);
    obs_t o;
    exp_t e;
    waitIdle(tag, budget);
    checkOutput({tag, " frame count"}, obsQ.size(), expQ.size());
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checkOutput({tag, " channel"}, o.cs, e.cs);
      checkOutput({tag, " word"}, o.word, e.word);
      checkOutput({tag, " sampled bits"}, o.bits, DATA_W);
      checkOutput({tag, " sck edges"}, o.edges, 2 * DATA_W);
      checkOutput({tag, " sck at cpol around cs"}, o.idleOk, 1);
    end
    obsQ.delete();
    expQ.delete();
    checkOutput({tag, " frame_done pulses"}, fdPulses, expFrames);
    checkOutput({tag, " frame_done aligned"}, fdBad, 0);
    checkOutput({tag, " dup_drop pulses"}, dupPulses, expDups);
    checkOutput({tag, " one cs low"}, multiLow, 0);
    checkOutput({tag, " gap >= CS_GAP"}, 32'(minGap >= CS_GAP), 1);
  endtask

  task automatic setMode(input logic p, input logic h);
    cpol = p;
    cpha = h;
    repeat (2) @(negedge clk);
    checkOutput("sck idles at cpol", sck, p);
  endtask

  task automatic waitCsLow(input string tag, input int budget);
    int n = 0;
    while (csN === '1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, " cs_n fell in budget"}, 32'(n < budget), 1);
  endtask

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int burst;
    logic [DATA_W-1:0] w;

    // reset state, with cpol high so sck must move off its reset value after
    cpol = 1'b1;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset sck", sck, 0);
    checkOutput("reset mosi", mosi, 0);
    checkOutput("reset cs_n", csN, 2'b11);
    checkOutput("reset wr_ready", wrReady, 1);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset frame_done", frameDone, 0);
    checkOutput("reset dup_drop", dupDrop, 0);
    checkOutput("reset overflow", overflow, 0);
    rstn = 1'b1;
    for (int i = 0; i < NUM_CS; i++) lastValid[i] = 1'b0;
    @(negedge clk);
    checkOutput("sck follows cpol after reset", sck, 1);
    setMode(1'b0, 1'b0);

    // mode 0 directed frame and accept-to-cs_n latency
    startSection();
    applyStimulus(16'hA5C3, 0, 1'b1);
    checkOutput("cs_n high 1 cycle after accept", csN, 2'b11);
    @(negedge clk);
    checkOutput("cs_n high 1 cycle after pop", csN, 2'b11);
    @(negedge clk);
    checkOutput("cs_n[0] low 2 cycles after accept", csN, 2'b10);
    endSection("mode0", 300);

    // modes 1..3 with the same word; reset between them so no dup drop
    for (int m = 1; m < 4; m++) begin
      doReset();
      startSection();
      setMode(m[1], m[0]);
      applyStimulus(16'h8001, 1, 1'b1);
      if (m == 3) begin
        waitCsLow("mode3", 20);
        repeat (10) @(negedge clk);
        cpol = 1'b0;
        cpha = 1'b0;
      end
      endSection($sformatf("mode%0d", m), 300);
    end
    setMode(1'b0, 1'b0);

    // duplicate suppression
    doReset();
    startSection();
    applyStimulus(16'h1234, 0, 1'b1);
    applyStimulus(16'h1234, 0, 1'b1);
    applyStimulus(16'h1235, 0, 1'b1);
    applyStimulus(16'h1234, 1, 1'b1);
    endSection("skipdup", 800);
    doReset();
    startSection();
    applyStimulus(16'h0000, 0, 1'b1);
    endSection("zero after reset", 300);

    // FIFO fill: one in flight + four queued, the sixth write overflows
    startSection();
    for (int i = 0; i < 5; i++) applyStimulus(16'h3000 + 16'(i), i % 2, 1'b1);
    checkOutput("overflow before extra write", overflow, 0);
    applyStimulus(16'h3FFF, 0, 1'b0);
    checkOutput("overflow after write while full", overflow, 1);
    endSection("fifo fill", 1200);
    checkOutput("overflow stays set", overflow, 1);

    // invalid channel is silently discarded, next write still works
    startSection();
    applyStimulus(16'h7777, 3, 1'b1);
    repeat (10) @(negedge clk);
    checkOutput("no cs for invalid channel", csN, 2'b11);
    applyStimulus(16'h4242, 0, 1'b1);
    endSection("invalid cs", 300);

    // randomized bursts against the model, mode changes between bursts
    for (burst = 0; burst < 6; burst++) begin
      startSection();
      setMode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 9) < 4) w = ($urandom_range(0, 1) != 0) ? 16'h5A5A : 16'h00FF;
        else w = 16'($urandom);
        applyStimulus(w, $urandom_range(0, 3), 1'b1);
      end
      endSection($sformatf("random burst %0d", burst), 1200);
    end

    // reset in the middle of shifting 0xFFFF
    doReset();
    setMode(1'b0, 1'b0);
    applyStimulus(16'hFFFF, 0, 1'b1);
    n = 0;
    while (!(inFrame && monBits >= 8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached bit 7 in budget", 32'(n < 200), 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("mid reset cs_n", csN, 2'b11);
    checkOutput("mid reset sck", sck, 0);
    checkOutput("mid reset mosi", mosi, 0);
    checkOutput("mid reset busy", busy, 0);
    checkOutput("mid reset frame_done", frameDone, 0);
    checkOutput("mid reset overflow", overflow, 0);
    checkOutput("mid reset wr_ready", wrReady, 1);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < NUM_CS; i++) lastValid[i] = 1'b0;
    obsQ.delete();
    expQ.delete();
    startSection();
    repeat (100) @(negedge clk);
    checkOutput("no frame after reset release", obsQ.size(), 0);
    checkOutput("no frame_done after reset release", fdPulses, 0);
    checkOutput("cs_n idle after reset release", csN, 2'b11);
    applyStimulus(16'hFFFF, 0, 1'b1);
    endSection("after mid reset", 300);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
